// File: rtl/switch_pkg.sv
// switch_pkg: declarations shared by the switch port transmitter and switch_top.
//   ADR_W       - width of a destination port address (four ports)
//   DW_DEF      - default payload width
//   DEPTH_DEF   - default log2 of FIFO entries
//   TIMEOUT_DEF - default REQ cycles without ack before the timeout flag sets
//   tx_state_e  - transmitter FSM encoding
package switch_pkg;
    localparam int ADR_W       = 2;
    localparam int DW_DEF      = 4;
    localparam int DEPTH_DEF   = 2;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } tx_state_e;
endpackage

// File: rtl/switch_port_tx_if.sv
// switch_port_tx_if: local request bus plus switch-side four-phase handshake.
//   req_valid_i/req_adr_i/req_dat_i/req_ready_o - local push side
//   validtx/adr_o/dat_o/acktx                   - switch side
//
// Handshakes:
//   Local side is valid/ready: a request transfers on a rising clock edge
//   where req_valid_i && req_ready_o. req_valid_i may be raised without
//   waiting for ready; ready never depends combinationally on req_valid_i.
//   Switch side is four-phase: validtx rises with adr_o/dat_o stable, the
//   switch raises acktx, validtx falls, the switch drops acktx, and only
//   then may validtx rise again. acktx may be asynchronous to clk_i.
interface switch_port_tx_if #(
    parameter int DW = switch_pkg::DW_DEF
);
    import switch_pkg::*;

    logic             req_valid_i;
    logic [ADR_W-1:0] req_adr_i;
    logic [DW-1:0]    req_dat_i;
    logic             req_ready_o;
    logic             validtx;
    logic [ADR_W-1:0] adr_o;
    logic [DW-1:0]    dat_o;
    logic             acktx;

    // slave: the transmitter; master: the request source and switch model
    modport slave (
        input  req_valid_i, req_adr_i, req_dat_i, acktx,
        output req_ready_o, validtx, adr_o, dat_o
    );
    modport master (
        output req_valid_i, req_adr_i, req_dat_i, acktx,
        input  req_ready_o, validtx, adr_o, dat_o
    );
endinterface

// File: rtl/switch_tx_fifo.sv
// switch_tx_fifo: 2**DEPTH entry FIFO, W bits wide, no bypass.
//   clk_i, rst_i - clock, async active-low reset (pointers only)
//   push, wdata  - write; caller guarantees space (or a same-cycle pop)
//   pop          - advance the read pointer; caller guarantees non-empty
//   rdata        - head entry, valid when !empty
//   full, empty  - occupancy flags
module switch_tx_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int N = 1 << DEPTH;

    logic [W-1:0]   mem [N];
    // Extra MSB is the wrap bit that distinguishes full from empty.
    logic [DEPTH:0] wr_ptr;
    logic [DEPTH:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH] != rd_ptr[DEPTH]) &&
                   (wr_ptr[DEPTH-1:0] == rd_ptr[DEPTH-1:0]);
    assign rdata = mem[rd_ptr[DEPTH-1:0]];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[DEPTH-1:0]] <= wdata;
    end
endmodule

// File: rtl/switch_port_tx.sv
// switch_port_tx: source endpoint for one switch input port.
//   clk_i, rst_i - clock, async active-low reset
//   port         - local request push side and switch handshake side
//   err_clr_i    - clears the sticky timeout flag
//   busy_o       - FSM not IDLE or FIFO holds requests
//   sent_cnt_o   - completed transfers, 8-bit wrapping
//   timeout_o    - sticky: a REQ waited TIMEOUT cycles without ack
//   state_o      - current FSM state, for observation
module switch_port_tx
    import switch_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    switch_port_tx_if.slave   port,
    input  logic              err_clr_i,
    output logic              busy_o,
    output logic [7:0]        sent_cnt_o,
    output logic              timeout_o,
    output tx_state_e         state_o
);
    localparam int W  = ADR_W + DW;
    // Counter reaches TIMEOUT and saturates so the timeout event fires once.
    localparam int TW = (TIMEOUT >= 1) ? $clog2(TIMEOUT + 1) : 1;

    tx_state_e     state, state_n;
    logic          ack_meta, ack_s;
    logic          push, pop, load;
    logic          full, empty;
    logic [W-1:0]  head;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_evt;

    // Two-flop synchroniser; acktx may come from another clock domain.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= port.acktx;
            ack_s    <= ack_meta;
        end
    end

    // A slot freed by this cycle's pop may be refilled in the same cycle.
    assign port.req_ready_o = !full || pop;
    assign push = port.req_valid_i && port.req_ready_o;

    switch_tx_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata ({port.req_adr_i, port.req_dat_i}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        pop     = 1'b0;
        case (state)
            // A high ack_s here is the tail of the previous transfer.
            IDLE: if (!empty && !ack_s) begin
                load    = 1'b1;
                state_n = REQ;
            end
            REQ: if (ack_s) begin
                pop     = 1'b1;
                state_n = REL;
            end
            REL: if (!ack_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // validtx is decoded from the async-reset state flop, so reset drops it at once.
    assign port.validtx = (state == REQ);
    assign busy_o       = (state != IDLE) || !empty;
    assign state_o      = state;

    assign tmo_evt = (TIMEOUT != 0) && (state == REQ) && !ack_s &&
                     (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            port.adr_o <= '0;
            port.dat_o <= '0;
            sent_cnt_o <= '0;
            tmo_cnt    <= '0;
            timeout_o  <= 1'b0;
        end else begin
            if (load) begin
                port.adr_o <= head[W-1:DW];
                port.dat_o <= head[DW-1:0];
                tmo_cnt    <= '0;
            end else if (state == REQ && !ack_s && tmo_cnt != TW'(TIMEOUT)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (pop) sent_cnt_o <= sent_cnt_o + 8'd1;
            // A timeout in the same cycle as a clear leaves the flag set.
            if (tmo_evt)        timeout_o <= 1'b1;
            else if (err_clr_i) timeout_o <= 1'b0;
        end
    end
endmodule

// File: doc/switch_port_tx.md
Name: switch_port_tx

Overview:
- Source-side endpoint for one switch input port.
- Accepts local requests (address + data) into a small FIFO.
- Drives each request onto the switch port with a four-phase valid/ack handshake: validtx, adr, dat out; acktx in.
- acktx may originate in the switch's other clock domain, so it is synchronised internally.
- Four instances, one per port, feed a switch_top.

Parameters:
- DW, 4, data width of each request.
- DEPTH, 2, log2 of FIFO entries (2**DEPTH = 4 entries).
- TIMEOUT, 64, cycles in REQ without ack before timeout_o sets; 0 disables the timeout.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  local push request
- req_adr_i  in  2  destination port of the request
- req_dat_i  in  DW  payload
- req_ready_o  out  1  FIFO not full; push occurs when req_valid_i && req_ready_o
- validtx  out  1  handshake request to switch
- adr_o  out  2  destination, stable while validtx=1
- dat_o  out  DW  payload, stable while validtx=1
- acktx  in  1  handshake acknowledge from switch (asynchronous)
- err_clr_i  in  1  clears timeout_o
- busy_o  out  1  FSM not IDLE or FIFO non-empty
- sent_cnt_o  out  8  completed transfers, wraps 255->0
- timeout_o  out  1  sticky timeout flag

Behaviour:
Reset (rst_i=0, async):
- validtx=0, adr_o=0, dat_o=0, sent_cnt_o=0, timeout_o=0, busy_o=0, req_ready_o=1.
- FIFO empty, FSM IDLE, synchroniser flops 0.
- Reset mid-handshake abandons the transfer and drops validtx immediately; FIFO contents are lost.

Synchroniser:
- ack_s = acktx through 2 flops.
- All FSM decisions use ack_s only.

FIFO:
- 2**DEPTH entries of {adr, dat}; pointers are DEPTH+1 bits with wrap bit.
- full when pointer MSBs differ and the rest are equal; empty when equal.
- Push when req_valid_i && !full. Push while full is ignored (req_ready_o=0).
- Pop only on the REQ->REL transition.
- Simultaneous push and pop are both honoured; count is unchanged.
- No bypass: a push into an empty FIFO is visible to the FSM the next cycle.

FSM:
- IDLE:
  - if FIFO non-empty and ack_s=0, register the head into adr_o/dat_o, set validtx=1, go to REQ.
  - if ack_s=1, stay (stale ack from previous transfer).
- REQ:
  - validtx=1; adr_o/dat_o held.
  - When ack_s=1: validtx=0, pop the FIFO, sent_cnt_o+1, go to REL.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1, set timeout_o=1 and keep waiting; validtx is never dropped without an ack.
- REL:
  - validtx=0; wait for ack_s=0, then go to IDLE.
  - Back-to-back transfers are allowed: IDLE re-issues the next cycle if the FIFO is non-empty.

Latency and counters:
- Push to validtx rise, empty FIFO: 2 cycles (write, then IDLE->REQ).
- Minimum cycles per transfer with immediate ack: ~7 (2-flop sync each direction of ack).
- Timeout counter clears on entering REQ.
- timeout_o clears on err_clr_i. If err_clr_i and the timeout event coincide, set wins.
- sent_cnt_o is 8-bit modulo.
- adr_o/dat_o keep their last values in IDLE/REL (no return to 0).
- busy_o = (state!=IDLE) || !empty.

Decomposition:
- Shared package switch_pkg:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, REL=2'd2).
  - Port-address width constant ADR_W=2.
  - Default DW/DEPTH constants shared with switch_top.
- One natural sub-module, switch_tx_fifo: parameterised DW+ADR_W wide, 2**DEPTH deep, push/pop/full/empty.
- The synchroniser and FSM stay in switch_port_tx.

Test Plan:
- Reset then idle: rst_i=0 for 3 cycles, release -> validtx=0, req_ready_o=1, sent_cnt_o=0, busy_o=0.
- Single transfer: push adr=2, dat=4'hA; bench responder raises acktx 3 cycles after validtx and drops it 2 cycles after validtx falls -> adr_o=2, dat_o=A stable throughout REQ; validtx falls 2-3 cycles after acktx; sent_cnt_o=1.
- FIFO full: push 5 requests with no ack -> req_ready_o=0 after the 4th push, 5th ignored. Then ack all -> exactly 4 transfers in push order (adr 0,1,2,3 / dat 1,2,3,4); sent_cnt_o=4.
- Simultaneous push/pop at full: push on the cycle REQ->REL pops -> push accepted, count stays 4, order preserved.
- Timeout: TIMEOUT=16, no ack -> timeout_o=1 after 16 REQ cycles, validtx still 1. Late ack completes the transfer. err_clr_i pulse -> timeout_o=0.
- Reset mid-REQ: assert rst_i while validtx=1 -> validtx=0 asynchronously, FIFO empty, sent_cnt_o=0; a subsequent push transfers normally.
